roi_pixel_packer: RTL and testbench

Downstream stage of the ROI crop. It takes the cropped push-only pixel stream, which has no back-pressure, and packs `LANES` consecutive 8-bit pixels into one wide word. Packed words are buffered in an internal FIFO and presented on a full AXI-Stream master with `tready`, so a DMA or bus bridge can stall without losing data. When the FIFO overflows, the block drops the rest of the current line cleanly, reports a sticky error, and realigns on the next `tlast`.

---
 rtl/roi_pixel_packer.sv | 187 ++++++++++++++++++
 tb/tb_roi_pixel_packer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/roi_pixel_packer.sv
// Purpose : packs LANES consecutive pixels of a push-only stream into one word
//           and buffers the words in a FIFO behind an AXI-Stream master.
// Latency : 1 cycle from the word-completing pixel to m_tvalid_o (FIFO empty).
// Backpr. : m_tready_i stalls the FIFO only. The pixel input cannot be stalled.
//           On overflow the rest of the line is dropped and ovf_o is set.
//           Packing realigns on the next tlast_i.
//
// Ports:
//   clk_i, arst_i              clock, asynchronous active-high reset
//   tdata_i/tvalid_i/tlast_i   cropped pixel stream in (no ready)
//   m_tdata_o/m_tkeep_o/m_tvalid_o/m_tlast_o/m_tready_i   packed AXIS master
//   ovf_o, ovf_clr_i           sticky overflow flag and its clear
//   drop_cnt_o                 dropped-word count
//
// Optional feature: define ROI_PACK_DROP_CNT_EN to get a 16-bit saturating
// drop counter. Without it, drop_cnt_o is tied to 0.
module roi_pixel_packer #(
  parameter int AXIS_DATA_W = 8,
  parameter int LANES       = 4,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic [AXIS_DATA_W-1:0]       tdata_i,
  input  logic                         tvalid_i,
  input  logic                         tlast_i,
  output logic [AXIS_DATA_W*LANES-1:0] m_tdata_o,
  output logic [LANES-1:0]             m_tkeep_o,
  output logic                         m_tvalid_o,
  output logic                         m_tlast_o,
  input  logic                         m_tready_i,
  output logic                         ovf_o,
  input  logic                         ovf_clr_i,
  output logic [15:0]                  drop_cnt_o
);

  localparam int WORD_W = AXIS_DATA_W * LANES;
  localparam int IDX_W  = $clog2(LANES);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic              last;
    logic [LANES-1:0]  keep;
    logic [WORD_W-1:0] dat;
  } ent_t;

  typedef enum logic {ST_RUN, ST_DROP} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] drop_lane_q;   // pixel position inside a discarded word
  logic [WORD_W-1:0] pack_q;
  logic             ovf_q;

  ent_t             mem_q [FIFO_DEPTH];
  ent_t             head_q;         // registered copy of the FIFO head
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_nxt;

  ent_t word_ent;
  logic at_end, run_done, push, pop, full, run_drop, drop_bnd, drop_evt;

  // Current word = pack register with the incoming pixel merged in at lane idx.
  // Lanes above idx are still zero, because the pack register is cleared
  // every time a word completes.
  always_comb begin
    word_ent      = '0;
    word_ent.last = tlast_i;
    for (int l = 0; l < LANES; l++) begin
      if (l == int'(idx_q)) begin
        word_ent.dat[l*AXIS_DATA_W +: AXIS_DATA_W] = tdata_i;
        word_ent.keep[l] = 1'b1;
      end else if (l < int'(idx_q)) begin
        word_ent.dat[l*AXIS_DATA_W +: AXIS_DATA_W] = pack_q[l*AXIS_DATA_W +: AXIS_DATA_W];
        word_ent.keep[l] = 1'b1;
      end
    end
  end

  assign pop      = (count_q != '0) & m_tready_i;
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign at_end   = (idx_q == IDX_W'(LANES - 1)) | tlast_i;
  assign run_done = tvalid_i & (state_q == ST_RUN) & at_end;
  // A slot frees up in the same cycle when the full FIFO is also being popped.
  assign push     = run_done & (~full | pop);
  assign run_drop = run_done & full & ~pop;
  assign drop_bnd = tvalid_i & (state_q == ST_DROP) &
                    ((drop_lane_q == IDX_W'(LANES - 1)) | tlast_i);
  assign drop_evt = run_drop | drop_bnd;
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  assign rd_nxt   = rd_ptr_q + PTR_W'(1);

  // Packing FSM, FIFO pointers and head register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= ST_RUN;
      idx_q       <= '0;
      drop_lane_q <= '0;
      pack_q      <= '0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tvalid_i) begin
            if (at_end) begin
              idx_q  <= '0;
              pack_q <= '0;
              // A line that ends on the dropped word needs no realignment.
              if (run_drop && !tlast_i) begin
                state_q     <= ST_DROP;
                drop_lane_q <= '0;
              end
            end else begin
              idx_q  <= idx_q + IDX_W'(1);
              pack_q <= word_ent.dat;
            end
          end
        end
        ST_DROP: begin
          if (tvalid_i) begin
            if (tlast_i) begin
              state_q     <= ST_RUN;
              drop_lane_q <= '0;
            end else begin
              drop_lane_q <= drop_lane_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= ST_RUN;
      endcase

      if (drop_evt)       ovf_q <= 1'b1;
      else if (ovf_clr_i) ovf_q <= 1'b0;

      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_nxt;
      count_q <= count_d;

      // Keep head_q equal to the oldest stored word. When the word being
      // pushed becomes the head in this cycle, bypass the memory.
      if (pop) begin
        if (count_q == CNT_W'(1) && push) head_q <= word_ent;
        else if (count_q > CNT_W'(1))     head_q <= mem_q[rd_nxt];
      end else if (count_q == '0 && push) begin
        head_q <= word_ent;
      end
    end
  end

  // The storage array has no reset. Its entries are only read after a write.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= word_ent;
  end

`ifdef ROI_PACK_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // An increment wins over a same-cycle clear, so the result is 1.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      drop_cnt_q <= '0;
    end else if (drop_evt) begin
      if (ovf_clr_i)                  drop_cnt_q <= 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end else if (ovf_clr_i) begin
      drop_cnt_q <= '0;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

  assign m_tdata_o  = head_q.dat;
  assign m_tkeep_o  = head_q.keep;
  assign m_tlast_o  = head_q.last;
  assign m_tvalid_o = (count_q != '0);
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_roi_pixel_packer.sv
// Bench for roi_pixel_packer with directed line stimulus.
// The behavioural model works on a per-line pixel list and a bounded word queue.
// A per-cycle compare checks the DUT outputs against that model.
// Literal expectations at key points pin the model itself.
module tb_roi_pixel_packer;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic [7:0]  tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b1;
  logic        ovf;
  logic        ovf_clr = 1'b0;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  roi_pixel_packer #(.AXIS_DATA_W(8), .LANES(4), .FIFO_DEPTH(16)) dut (
    .clk_i(clk), .arst_i(arst),
    .tdata_i(tdata), .tvalid_i(tvalid), .tlast_i(tlast),
    .m_tdata_o(m_tdata), .m_tkeep_o(m_tkeep), .m_tvalid_o(m_tvalid),
    .m_tlast_o(m_tlast), .m_tready_i(m_tready),
    .ovf_o(ovf), .ovf_clr_i(ovf_clr), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

`ifdef ROI_PACK_DROP_CNT_EN
  localparam int EXP_OVF_DROPS = 4;
`else
  localparam int EXP_OVF_DROPS = 0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } w_t;

  w_t  mq[$];          // words the FIFO must hold, oldest first
  byte pend[$];        // pixels of the word being built
  bit  dropping = 0;
  int  drop_run = 0;
  bit  m_ovf = 0;
  int  m_drop = 0;

  task automatic model_step();
    bit pop;
    bit evt;
    w_t w;
    if (arst) begin
      mq.delete(); pend.delete();
      dropping = 0; drop_run = 0; m_ovf = 0; m_drop = 0;
      return;
    end
    pop = (mq.size() != 0) && m_tready;
    evt = 0;
    if (tvalid) begin
      if (!dropping) begin
        pend.push_back(tdata);
        if (pend.size() == 4 || tlast) begin
          w.d = '0;
          foreach (pend[k]) w.d[k*8 +: 8] = pend[k];
          w.k = 4'((1 << pend.size()) - 1);
          w.l = tlast;
          pend.delete();
          if (mq.size() < 16 || pop) mq.push_back(w);
          else begin
            evt = 1;
            if (!tlast) begin dropping = 1; drop_run = 0; end
          end
        end
      end else begin
        drop_run++;
        if (drop_run == 4 || tlast) begin evt = 1; drop_run = 0; end
        if (tlast) dropping = 0;
      end
    end
    if (pop) mq.delete(0);
    if (evt) begin
      m_ovf = 1;
`ifdef ROI_PACK_DROP_CNT_EN
      if (ovf_clr) m_drop = 1;
      else if (m_drop < 65535) m_drop++;
`endif
    end else if (ovf_clr) begin
      m_ovf = 0;
      m_drop = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge arst);
    model_step();
  end

  // Per-cycle compare, taken on the falling edge
  initial forever begin
    @(negedge clk);
    chk("cyc_vld", 64'(m_tvalid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("cyc_data", 64'(m_tdata), 64'(mq[0].d));
      chk("cyc_keep", 64'(m_tkeep), 64'(mq[0].k));
      chk("cyc_last", 64'(m_tlast), 64'(mq[0].l));
    end
    chk("cyc_ovf",  64'(ovf), 64'(m_ovf));
    chk("cyc_drop", 64'(drop_cnt), 64'(m_drop));
  end

  // ---------------- stimulus ----------------
  task automatic px(input logic [7:0] d, input logic l);
    tdata = d; tvalid = 1'b1; tlast = l;
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  function automatic logic [31:0] exp_w(input int base);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = 8'(base + b);
    return r;
  endfunction

  // Pixels v = 0..n-1 as one line, tlast on the final pixel
  task automatic line(input int n);
    for (int i = 0; i < n; i++) px(8'(i), i == n - 1);
  endtask

  // Pops n words, starting at word index k0 of a 0,1,2.. pixel line.
  // The final word's last flag must be fin_last.
  task automatic drain(input int k0, input int n, input logic fin_last);
    m_tready = 1'b1;
    for (int k = 0; k < n; k++) begin
      chk("drain_vld",  64'(m_tvalid), 64'(1));
      chk("drain_data", 64'(m_tdata), 64'(exp_w(4 * (k0 + k))));
      chk("drain_last", 64'(m_tlast), 64'((k == n - 1) ? fin_last : 1'b0));
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(m_tvalid), 64'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld",  64'(m_tvalid), 64'(0));
    chk("rst_data", 64'(m_tdata), 64'(0));
    chk("rst_keep", 64'(m_tkeep), 64'(0));
    chk("rst_last", 64'(m_tlast), 64'(0));
    chk("rst_ovf",  64'(ovf), 64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));
    arst = 1'b0;
    @(posedge clk); #1;

    // Basic pack
    m_tready = 1'b1;
    for (int i = 1; i <= 4; i++) px(8'(i), 1'b0);
    chk("basic_w0_vld",  64'(m_tvalid), 64'(1));
    chk("basic_w0_data", 64'(m_tdata), 64'h04030201);
    chk("basic_w0_keep", 64'(m_tkeep), 64'hF);
    chk("basic_w0_last", 64'(m_tlast), 64'(0));
    for (int i = 5; i <= 8; i++) px(8'(i), i == 8);
    chk("basic_w1_data", 64'(m_tdata), 64'h08070605);
    chk("basic_w1_keep", 64'(m_tkeep), 64'hF);
    chk("basic_w1_last", 64'(m_tlast), 64'(1));

    // Partial last word
    px(8'hAA, 1'b0); px(8'hBB, 1'b0); px(8'hCC, 1'b1);
    chk("part_data", 64'(m_tdata), 64'h00CCBBAA);
    chk("part_keep", 64'(m_tkeep), 64'h7);
    chk("part_last", 64'(m_tlast), 64'(1));
    @(posedge clk); #1;

    // Back-pressure: 16 words fill the FIFO exactly
    m_tready = 1'b0;
    line(64);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_vld",  64'(m_tvalid), 64'(1));
    chk("bp_hold", 64'(m_tdata), 64'(exp_w(0)));
    chk("bp_ovf",  64'(ovf), 64'(0));
    drain(0, 16, 1'b1);

    // Overflow: 80-pixel line into a stalled FIFO
    m_tready = 1'b0;
    line(80);
    chk("ovf_flag", 64'(ovf), 64'(1));
    chk("ovf_cnt",  64'(drop_cnt), 64'(EXP_OVF_DROPS));
    chk("ovf_head", 64'(m_tdata), 64'(exp_w(0)));
    drain(0, 16, 1'b0);
    for (int i = 1; i <= 4; i++) px(8'(8'h10 + i), i == 4);
    chk("ovf_next_data", 64'(m_tdata), 64'h14131211);
    chk("ovf_next_keep", 64'(m_tkeep), 64'hF);
    chk("ovf_next_last", 64'(m_tlast), 64'(1));
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("clr_ovf",  64'(ovf), 64'(0));
    chk("clr_drop", 64'(drop_cnt), 64'(0));

    // Full FIFO with a same-cycle pop on the completing pixel
    m_tready = 1'b0;
    for (int i = 0; i < 67; i++) px(8'(i), 1'b0);
    m_tready = 1'b1;
    px(8'd67, 1'b1);
    m_tready = 1'b0;
    chk("fullpop_ovf",  64'(ovf), 64'(0));
    chk("fullpop_head", 64'(m_tdata), 64'(exp_w(4)));
    drain(1, 16, 1'b1);

    // Mid-line reset with a word queued
    m_tready = 1'b0;
    for (int i = 1; i <= 4; i++) px(8'(i), 1'b0);
    px(8'h05, 1'b0); px(8'h06, 1'b0);
    chk("pre_rst_vld", 64'(m_tvalid), 64'(1));
    #2 arst = 1'b1;
    #1;
    chk("mrst_vld",  64'(m_tvalid), 64'(0));
    chk("mrst_data", 64'(m_tdata), 64'(0));
    chk("mrst_keep", 64'(m_tkeep), 64'(0));
    chk("mrst_last", 64'(m_tlast), 64'(0));
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    m_tready = 1'b1;
    for (int i = 1; i <= 4; i++) px(8'(i), i == 4);
    chk("post_rst_data", 64'(m_tdata), 64'h04030201);
    chk("post_rst_keep", 64'(m_tkeep), 64'hF);
    chk("post_rst_last", 64'(m_tlast), 64'(1));
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench did not complete");
  end

endmodule
